vend_input_conditioner: RTL and testbench
=========================================

VEND_INPUT_CONDITIONER -- requirements
Module: vend_input_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16, the number of consecutive stable cycles required to accept a level change (range 2..2^20).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports quarter_raw, dime_raw, nickel_raw, soda_raw, diet_raw, each input, 1 bit: unsynchronised switch/button levels, active-high.
REQ-005 The block SHALL have ports quarter, dime, nickel, soda, diet, each output, 1 bit: registered single-cycle event pulses that drive the vending FSM's inputs of the same names.

Function
REQ-006 Each raw input SHALL pass through a two-flop synchroniser before any other logic.
REQ-007 Each channel SHALL hold a debounced stable level and a counter: the counter clears whenever the synchronised input equals the stable level, and otherwise increments.
REQ-008 When the counter reaches DB_CYCLES-1 while still mismatched, the stable level SHALL toggle on that edge and the counter SHALL clear.
REQ-009 A bounce (sync input returning to the stable level) before the count completes SHALL clear the counter with no level change.
REQ-010 A 0->1 transition of a stable level SHALL set that channel's pending bit; a 1->0 transition SHALL produce no event.
REQ-011 A rising stable edge on a channel whose pending bit is already set SHALL be absorbed (no second event is queued).
REQ-012 Each cycle the arbiter SHALL grant at most one pending channel, in fixed priority quarter > dime > nickel > soda > diet, and assert exactly that output for one cycle.
REQ-013 A granted pending bit SHALL clear on the grant edge; ungranted bits SHALL persist and be granted in later cycles in priority order.
REQ-014 Without contention, an output pulse SHALL rise exactly DB_CYCLES+3 rising edges after the first edge that samples the raw input high and stays high.
REQ-015 At most one of the five outputs SHALL be high in any cycle.
REQ-016 A held input SHALL produce exactly one pulse per press; a new pulse requires a debounced release followed by a debounced press.

Reset
REQ-017 Reset SHALL immediately clear all synchronisers, stable levels, counters, pending bits and outputs to 0, including mid-debounce and with events pending; queued events SHALL be discarded.
REQ-018 A raw input held high through reset deassertion SHALL be treated as a new press and yield one pulse DB_CYCLES+3 edges after the first post-reset sampling edge.

Configuration
REQ-019 With macro VEND_INPUT_TOTAL_EN defined, the block SHALL add output coin_total, 8 bits: a running cents sum incremented by 25/10/5 on each quarter/dime/nickel pulse, saturating at 255, cleared only by reset.
REQ-020 Without VEND_INPUT_TOTAL_EN, coin_total and its adder SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-021 A shared package vend_pkg SHALL hold the channel count (5), channel index constants in priority order, and coin values (25, 10, 5).
REQ-022 Per-channel synchroniser, debounce counter and stable-level logic SHALL be one sub-module, vend_debounce_ch, instantiated five times with DB_CYCLES passed through.
REQ-023 The counter width SHALL be $clog2(DB_CYCLES) bits.

Verification (DB_CYCLES=16)
REQ-024 Clean press: dime_raw held high for 40 cycles -> dime high for exactly one cycle, at edge 19 after the first sampling edge; no other outputs.
REQ-025 Bounce: nickel_raw toggled with 3 cycles high and 3 cycles low for 30 cycles, then held high -> exactly one nickel pulse, 19 edges after the final rise.
REQ-026 Simultaneous presses: all five raw inputs rise on the same edge -> quarter, dime, nickel, soda, diet pulse on five consecutive cycles in that order.
REQ-027 Reset mid-operation: reset asserted 10 cycles into a quarter press and held for 2 cycles -> outputs 0 at once; one quarter pulse 19 edges after reset release if quarter_raw is still high.
REQ-028 Held input plus re-press: soda_raw held high for 200 cycles -> one pulse; then low for 20 cycles and high again -> a second pulse.
REQ-029 With VEND_INPUT_TOTAL_EN: 11 quarter presses -> coin_total goes 25, 50, ..., 250, then saturates at 255; stays 255 after a further nickel press.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared channel indices, channel count and coin values for the
//               vending input conditioner, plus arbitration/saturation helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  localparam int unsigned C_NUM_CH = 5;

  // Channel indices double as arbitration priority: lower index wins.
  localparam int unsigned C_CH_QUARTER = 0;
  localparam int unsigned C_CH_DIME    = 1;
  localparam int unsigned C_CH_NICKEL  = 2;
  localparam int unsigned C_CH_SODA    = 3;
  localparam int unsigned C_CH_DIET    = 4;

  localparam logic [7:0] C_VAL_QUARTER = 8'd25;
  localparam logic [7:0] C_VAL_DIME    = 8'd10;
  localparam logic [7:0] C_VAL_NICKEL  = 8'd5;

  typedef logic [C_NUM_CH-1:0] ch_vec_t;

  // Isolates the lowest set bit, i.e. the highest-priority requester.
  function automatic ch_vec_t pick_highest(input ch_vec_t req);
    return req & (~req + ch_vec_t'(1));
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : vend_debounce_ch
// Description : One input channel: two-flop synchroniser followed by a
//               mismatch counter that flips the stable level after DB_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_debounce_ch
  import vend_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level agrees with stable restarts the count.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == C_CNT_MAX) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/vend_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : vend_input_conditioner
// Description : Debounces five coin/selection inputs and issues one-cycle,
//               priority-arbitrated event pulses. Define VEND_INPUT_TOTAL_EN
//               to add the saturating coin_total cents counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_input_conditioner
  import vend_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quarter_raw,
  input  logic       dime_raw,
  input  logic       nickel_raw,
  input  logic       soda_raw,
  input  logic       diet_raw,
  output logic       quarter,
  output logic       dime,
  output logic       nickel,
  output logic       soda,
  output logic       diet
`ifdef VEND_INPUT_TOTAL_EN
  ,
  output logic [7:0] coin_total
`endif
);

  ch_vec_t raw_vec;
  ch_vec_t stable_vec;
  ch_vec_t rise_vec;
  ch_vec_t grant_vec;
  ch_vec_t stable_prev_q, stable_prev_d;
  ch_vec_t pending_q, pending_d;
  ch_vec_t out_q, out_d;

  assign raw_vec[C_CH_QUARTER] = quarter_raw;
  assign raw_vec[C_CH_DIME]    = dime_raw;
  assign raw_vec[C_CH_NICKEL]  = nickel_raw;
  assign raw_vec[C_CH_SODA]    = soda_raw;
  assign raw_vec[C_CH_DIET]    = diet_raw;

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    vend_debounce_ch #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_vec[i]),
      .stable (stable_vec[i])
    );
  end

  // Release edges are ignored; a rise on an already-pending channel merges into it.
  always_comb begin
    stable_prev_d = stable_vec;
    rise_vec      = stable_vec & ~stable_prev_q;
    grant_vec     = pick_highest(pending_q);
    pending_d     = (pending_q & ~grant_vec) | rise_vec;
    out_d         = grant_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_prev_q <= '0;
      pending_q     <= '0;
      out_q         <= '0;
    end else begin
      stable_prev_q <= stable_prev_d;
      pending_q     <= pending_d;
      out_q         <= out_d;
    end
  end

  assign quarter = out_q[C_CH_QUARTER];
  assign dime    = out_q[C_CH_DIME];
  assign nickel  = out_q[C_CH_NICKEL];
  assign soda    = out_q[C_CH_SODA];
  assign diet    = out_q[C_CH_DIET];

`ifdef VEND_INPUT_TOTAL_EN
  logic [7:0] total_q, total_d;
  logic [7:0] coin_inc;

  always_comb begin
    coin_inc = 8'd0;
    if (out_q[C_CH_QUARTER]) begin
      coin_inc = C_VAL_QUARTER;
    end else if (out_q[C_CH_DIME]) begin
      coin_inc = C_VAL_DIME;
    end else if (out_q[C_CH_NICKEL]) begin
      coin_inc = C_VAL_NICKEL;
    end
    total_d = sat_add8(total_q, coin_inc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q <= 8'd0;
    end else begin
      total_q <= total_d;
    end
  end

  assign coin_total = total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vend_input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vend_input_conditioner
// Description : Self-checking bench with a cycle-level behavioural model and
//               directed press/bounce/reset/contention scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_input_conditioner;

  localparam int DB = 16;
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] raw = 5'b0;
  logic       quarter, dime, nickel, soda, diet;
  logic [4:0] dut_out;
`ifdef VEND_INPUT_TOTAL_EN
  logic [7:0] coin_total;
`endif

  always #5 clk = ~clk;

  vend_input_conditioner #(.DB_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .quarter_raw (raw[0]),
    .dime_raw    (raw[1]),
    .nickel_raw  (raw[2]),
    .soda_raw    (raw[3]),
    .diet_raw    (raw[4]),
    .quarter     (quarter),
    .dime        (dime),
    .nickel      (nickel),
    .soda        (soda),
    .diet        (diet)
`ifdef VEND_INPUT_TOTAL_EN
    ,
    .coin_total  (coin_total)
`endif
  );

  assign dut_out = {diet, soda, nickel, dime, quarter};

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int pulses[5];
  int last_edge[5];

  // Behavioural model: level delayed two edges, then a level change is accepted
  // on the DB-th consecutive differing edge; a rising change becomes a request
  // one edge later, and requests are served lowest-index first, one per edge.
  int         run[5];
  bit         m_s1[5], m_s2[5], m_st[5], m_rise[5], m_pend[5];
  logic [4:0] exp_out = 5'b0;
  int         exp_total = 0;

  function automatic int coin_value(input logic [4:0] v);
    if (v[0]) return 25;
    if (v[1]) return 10;
    if (v[2]) return 5;
    return 0;
  endfunction

  always @(posedge clk) edge_cnt++;

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      for (int c = 0; c < 5; c++) begin
        run[c] = 0; m_s1[c] = 0; m_s2[c] = 0; m_st[c] = 0; m_rise[c] = 0; m_pend[c] = 0;
      end
      exp_out   = 5'b0;
      exp_total = 0;
    end else begin
      exp_total = exp_total + coin_value(exp_out);
      if (exp_total > 255) exp_total = 255;
      g = -1;
      for (int c = 0; c < 5; c++) if (m_pend[c] && g < 0) g = c;
      exp_out = 5'b0;
      if (g >= 0) begin
        exp_out[g] = 1'b1;
        m_pend[g]  = 0;
      end
      for (int c = 0; c < 5; c++) begin
        if (m_rise[c]) m_pend[c] = 1;
        m_rise[c] = 0;
        if (m_s2[c] != m_st[c]) begin
          run[c]++;
          if (run[c] == DB) begin
            m_st[c] = !m_st[c];
            run[c]  = 0;
            if (m_st[c]) m_rise[c] = 1;
          end
        end else begin
          run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (dut_out !== exp_out) begin
      n_fail++;
      $display("FAIL outputs edge %0d: got %b expected %b", edge_cnt, dut_out, exp_out);
    end
    n_checks++;
    if (!$onehot0(dut_out)) begin
      n_fail++;
      $display("FAIL onehot edge %0d: got %b expected at most one bit", edge_cnt, dut_out);
    end
`ifdef VEND_INPUT_TOTAL_EN
    n_checks++;
    if (coin_total !== exp_total[7:0]) begin
      n_fail++;
      $display("FAIL coin_total edge %0d: got %0d expected %0d", edge_cnt, coin_total, exp_total);
    end
`endif
    for (int c = 0; c < 5; c++) begin
      if (dut_out[c] === 1'b1) begin
        pulses[c]++;
        last_edge[c] = edge_cnt;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 5; c++) begin
      pulses[c]    = 0;
      last_edge[c] = -1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    clear_counts();
    tick(3);
    check("reset_outputs", {27'd0, dut_out}, 32'd0);
    reset = 1'b0;
    tick(5);

    // Clean dime press
    clear_counts();
    raw[1] = 1'b1;
    e = edge_cnt + 1;
    tick(40);
    check("dime_count", pulses[1], 1);
    check("dime_edge", last_edge[1], e + LAT);
    check("dime_others", pulses[0] + pulses[2] + pulses[3] + pulses[4], 0);
    raw[1] = 1'b0;
    tick(40);
    check("dime_release_no_event", pulses[1], 1);

    // Bouncing nickel, then held
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      raw[2] = 1'b1; tick(3);
      raw[2] = 1'b0; tick(3);
    end
    raw[2] = 1'b1;
    e = edge_cnt + 1;
    tick(40);
    check("nickel_count", pulses[2], 1);
    check("nickel_edge", last_edge[2], e + LAT);
    raw[2] = 1'b0;
    tick(40);

    // All five at once: served on consecutive edges in priority order
    clear_counts();
    raw = 5'h1F;
    e = edge_cnt + 1;
    tick(40);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("simul_count_%0d", c), pulses[c], 1);
      check($sformatf("simul_edge_%0d", c), last_edge[c], e + LAT + c);
    end
    raw = 5'b0;
    tick(40);

    // Reset in the middle of a quarter press
    clear_counts();
    raw[0] = 1'b1;
    tick(10);
    reset = 1'b1;
    #1;
    check("reset_async_outputs", {27'd0, dut_out}, 32'd0);
    tick(2);
    reset = 1'b0;
    e = edge_cnt + 1;
    tick(40);
    check("reset_quarter_count", pulses[0], 1);
    check("reset_quarter_edge", last_edge[0], e + LAT);
    raw[0] = 1'b0;
    tick(40);

    // Held soda, then release and re-press
    clear_counts();
    raw[3] = 1'b1;
    e = edge_cnt + 1;
    tick(200);
    check("soda_held_count", pulses[3], 1);
    check("soda_held_edge", last_edge[3], e + LAT);
    raw[3] = 1'b0;
    tick(20);
    raw[3] = 1'b1;
    e = edge_cnt + 1;
    tick(40);
    check("soda_repress_count", pulses[3], 2);
    check("soda_repress_edge", last_edge[3], e + LAT);
    raw[3] = 1'b0;
    tick(40);

`ifdef VEND_INPUT_TOTAL_EN
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("total_after_reset", coin_total, 0);
    for (int k = 1; k <= 11; k++) begin
      raw[0] = 1'b1; tick(25);
      raw[0] = 1'b0; tick(25);
      check($sformatf("total_quarter_%0d", k), coin_total, (25 * k > 255) ? 255 : 25 * k);
    end
    raw[2] = 1'b1; tick(25);
    raw[2] = 1'b0; tick(25);
    check("total_saturated_nickel", coin_total, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
